pipe_scoreboard_ctrl: RTL

PIPE_SCOREBOARD_CTRL -- requirements
Module: pipe_scoreboard_ctrl

---
 rtl/pipe_scoreboard_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_scoreboard_ctrl.sv
// pipe_scoreboard_ctrl
//   Register scoreboard and pipeline control for an in-order pipeline with
//   multi-cycle loads. Each register owns a small countdown that is armed
//   when a load targeting it leaves ID. Any instruction in ID that reads or
//   writes a still-counting register is held (RAW and WAW). A debug FSM can
//   halt the whole pipeline and single-step it one cycle per step edge.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   issue_valid           instruction present in ID
//   issue_rs/_rt(_used)   source register numbers and whether they are read
//   issue_wr_en/_wr_addr  destination write enable and register
//   issue_is_load         instruction is a multi-cycle producer
//   flush_in              taken branch/jump; squash younger stages
//   debug_en, debug_step  halt request, single-step pulse/level
//   stat_clr              synchronous clear of the stall counter
//   stall                 hold IF/ID, bubble into EXE
//   id_flush              squash ID/EXE
//   issue_accept          instruction leaves ID this cycle
//   pipe_en               global stage enable (low while halted)
//   busy_vec              per-register pending-load flags
//   stall_cnt             saturating count of stalled cycles
module pipe_scoreboard_ctrl #(
  parameter int AW     = 5,
  parameter int LD_LAT = 2,
  parameter int DBG    = 1,
  parameter int CW     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [AW-1:0]        issue_rs,
  input  logic [AW-1:0]        issue_rt,
  input  logic                 issue_rs_used,
  input  logic                 issue_rt_used,
  input  logic                 issue_wr_en,
  input  logic [AW-1:0]        issue_wr_addr,
  input  logic                 issue_is_load,
  input  logic                 flush_in,
  input  logic                 debug_en,
  input  logic                 debug_step,
  input  logic                 stat_clr,
  output logic                 stall,
  output logic                 id_flush,
  output logic                 issue_accept,
  output logic                 pipe_en,
  output logic [(2**AW)-1:0]   busy_vec,
  output logic [CW-1:0]        stall_cnt
);

  localparam int         NREG = 2**AW;
  localparam logic [2:0] LAT  = 3'(LD_LAT);

  typedef enum logic [1:0] {RUN, HALT, STEP} state_t;

  state_t        state_q, state_d;
  logic          step_q;
  logic [2:0]    cnt_q [NREG];
  logic [2:0]    cnt_d [NREG];
  logic [CW-1:0] stall_cnt_q, stall_cnt_d;
  logic          hazard;
  logic          step_edge;
  logic          load_arm;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  always_comb begin
    for (int r = 0; r < NREG; r++) busy_vec[r] = (cnt_q[r] != 3'd0);
  end

  assign pipe_en      = (state_q != HALT);
  assign hazard       = (issue_rs_used & busy_vec[issue_rs]) |
                        (issue_rt_used & busy_vec[issue_rt]) |
                        (issue_wr_en   & busy_vec[issue_wr_addr]);
  // Flush outranks stall: the instruction in ID is being squashed anyway.
  assign stall        = issue_valid & hazard & pipe_en & ~flush_in;
  assign issue_accept = issue_valid & ~hazard & ~flush_in & pipe_en;
  assign id_flush     = flush_in & pipe_en;
  assign load_arm     = issue_accept & issue_is_load & issue_wr_en &
                        (issue_wr_addr != '0);
  assign step_edge    = debug_step & ~step_q;
  assign stall_cnt    = stall_cnt_q;

  // Countdowns advance only while the pipeline moves, so a halt freezes
  // the remaining load latency. Flush leaves them alone because the
  // producers are older than the branch.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      if (pipe_en) begin
        if (load_arm && (issue_wr_addr == AW'(r))) cnt_d[r] = LAT;
        else if (cnt_q[r] != 3'd0)                 cnt_d[r] = cnt_q[r] - 3'd1;
      end
    end
    cnt_d[0] = 3'd0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stat_clr)   stall_cnt_d = '0;
    else if (stall) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (debug_en) state_d = HALT;
      HALT:    if (!debug_en)     state_d = RUN;
               else if (step_edge) state_d = STEP;
      STEP:    state_d = debug_en ? HALT : RUN;
      default: state_d = RUN;
    endcase
    if (DBG == 0) state_d = RUN;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      step_q      <= 1'b0;
      stall_cnt_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= 3'd0;
    end else begin
      state_q     <= state_d;
      step_q      <= debug_step;
      stall_cnt_q <= stall_cnt_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

endmodule
